// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - shared constants for the iterative multiply/divide sequencer
package mult_div_pkg;

    localparam int MD_WIDTH = 32;

    // Sequencer states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PREP   = 3'd1;
    localparam logic [2:0] ST_ITER   = 3'd2;
    localparam logic [2:0] ST_FIX    = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_DONE_Z = 3'd5;

    // Operation encodings on the op port; bit 0 selects divide
    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_DIV   = 2'd1;
    localparam logic [1:0] OP_MULTU = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

endpackage

// File: rtl/mult_div_core.sv
// rtl/mult_div_core.sv - one shift-add / restoring-divide step plus final sign fix-up
module mult_div_core
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             is_div,
    input  logic             neg_q,
    input  logic             neg_r,
    input  logic [WIDTH-1:0] opnd,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    output logic [WIDTH-1:0] step_hi,
    output logic [WIDTH-1:0] step_lo,
    output logic [WIDTH-1:0] fix_hi,
    output logic [WIDTH-1:0] fix_lo
);

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] prod_neg;

    // Single iteration: multiply shifts the carry back into the upper half,
    // divide keeps the trial difference only when it did not borrow
    always_comb begin
        add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        rem_sh  = {acc_hi, acc_lo[WIDTH-1]};
        trial   = rem_sh - {1'b0, opnd};
        if (is_div) begin
            if (!trial[WIDTH]) begin
                step_hi = trial[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = rem_sh[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = add_sum[WIDTH:1];
            step_lo = {add_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Sign restoration: the product negates as one 2*WIDTH value, quotient and
    // remainder negate independently
    always_comb begin
        prod_neg = -{acc_hi, acc_lo};
        if (is_div) begin
            fix_lo = neg_q ? -acc_lo : acc_lo;
            fix_hi = neg_r ? -acc_hi : acc_hi;
        end else if (neg_q) begin
            fix_hi = prod_neg[2*WIDTH-1:WIDTH];
            fix_lo = prod_neg[WIDTH-1:0];
        end else begin
            fix_hi = acc_hi;
            fix_lo = acc_lo;
        end
    end

endmodule

// File: rtl/mult_div_ctrl.sv
// rtl/mult_div_ctrl.sv - multiply/divide sequencer with HI/LO; MULT_DIV_UNSIGNED_EN enables MULTU/DIVU
module mult_div_ctrl
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             is_div_q, is_div_d;
    logic             sgn_a_q, sgn_a_d;
    logic             sgn_b_q, sgn_b_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             signed_op;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] step_hi, step_lo, fix_hi, fix_lo;

`ifdef MULT_DIV_UNSIGNED_EN
    assign signed_op = ~op[1];
`else
    logic unused_op_hi;
    assign unused_op_hi = op[1];
    assign signed_op    = 1'b1;
`endif

    assign mag_a = sgn_a_q ? -a_q : a_q;
    assign mag_b = sgn_b_q ? -b_q : b_q;

    mult_div_core #(.WIDTH(WIDTH)) u_core (
        .is_div  (is_div_q),
        .neg_q   (sgn_a_q ^ sgn_b_q),
        .neg_r   (sgn_a_q),
        .opnd    (opnd_q),
        .acc_hi  (acc_hi_q),
        .acc_lo  (acc_lo_q),
        .step_hi (step_hi),
        .step_lo (step_lo),
        .fix_hi  (fix_hi),
        .fix_lo  (fix_lo)
    );

    // Next-state, operand capture, accumulator stepping and HI/LO updates
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        is_div_d = is_div_q;
        sgn_a_d  = sgn_a_q;
        sgn_b_d  = sgn_b_q;
        a_d      = a_q;
        b_d      = b_q;
        opnd_d   = opnd_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    is_div_d = op[0];
                    sgn_a_d  = signed_op & a[WIDTH-1];
                    sgn_b_d  = signed_op & b[WIDTH-1];
                    state_d  = (op[0] && (b == '0)) ? ST_DONE_Z : ST_PREP;
                end
            end
            ST_PREP: begin
                // Multiply: opnd is the multiplicand, acc_lo the multiplier.
                // Divide: opnd is the divisor, acc_lo the dividend.
                opnd_d   = is_div_q ? mag_b : mag_a;
                acc_lo_d = is_div_q ? mag_a : mag_b;
                acc_hi_d = '0;
                count_d  = '0;
                state_d  = ST_ITER;
            end
            ST_ITER: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                count_d  = count_q + 1'b1;
                if (count_q == LAST_STEP) state_d = ST_FIX;
            end
            ST_FIX: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                state_d = ST_DONE;
            end
            ST_DONE, ST_DONE_Z: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            is_div_q <= 1'b0;
            sgn_a_q  <= 1'b0;
            sgn_b_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            is_div_q <= is_div_d;
            sgn_a_q  <= sgn_a_d;
            sgn_b_q  <= sgn_b_d;
            a_q      <= a_d;
            b_q      <= b_d;
            opnd_q   <= opnd_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE) || (state_q == ST_DONE_Z);
    assign div_zero = (state_q == ST_DONE_Z);
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
